// File: rtl/mips_fetch_stage_if.sv
// I-cache read bus between the fetch stage (master) and the instruction cache (slave).
interface mips_fetch_stage_if;
    logic [31:0] iCacheReadAddr;
    logic [31:0] iCacheReadData;
    logic        iCacheHit;

    modport master (
        output iCacheReadAddr,
        input  iCacheReadData,
        input  iCacheHit
    );

    modport slave (
        input  iCacheReadAddr,
        output iCacheReadData,
        output iCacheHit
    );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC, I-cache address and IF/ID register.
// Define FETCH_DELAY_SLOT_EN to capture the branch-delay-slot instruction on a redirect.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    mips_fetch_stage_if.master        icache,
    input  logic                      stall_i,
    input  logic                      redirect_valid_i,
    input  logic [31:0]               redirect_target_i,
    output logic [31:0]               fetched_instr_o,
    output logic [31:0]               fetched_pc_o,
    output logic                      fetched_valid_o,
    output logic                      misalign_o,
    output logic [31:0]               fetch_count_o
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_MISS = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc_q;

    assign icache.iCacheReadAddr = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_BOOT;
            pc_q            <= RESET_PC;
            fetched_instr_o <= NOP_INSTR;
            fetched_pc_o    <= RESET_PC;
            fetched_valid_o <= 1'b0;
            misalign_o      <= 1'b0;
            fetch_count_o   <= 32'd0;
        end else begin
            misalign_o <= 1'b0;
            case (state)
                S_BOOT: begin
                    state <= S_RUN;
                end
                default: begin
                    if (redirect_valid_i) begin
                        pc_q       <= {redirect_target_i[31:2], 2'b00};
                        misalign_o <= |redirect_target_i[1:0];
                        state      <= S_RUN;
`ifdef FETCH_DELAY_SLOT_EN
                        // The instruction already at pc_q is the delay slot and still executes.
                        if (!stall_i) begin
                            if (icache.iCacheHit) begin
                                fetched_instr_o <= icache.iCacheReadData;
                                fetched_pc_o    <= pc_q;
                                fetched_valid_o <= 1'b1;
                                fetch_count_o   <= fetch_count_o + 32'd1;
                            end else begin
                                fetched_instr_o <= NOP_INSTR;
                                fetched_valid_o <= 1'b0;
                            end
                        end
`else
                        fetched_instr_o <= NOP_INSTR;
                        fetched_valid_o <= 1'b0;
`endif
                    end else if (stall_i) begin
                        state <= state;
                    end else if (!icache.iCacheHit) begin
                        fetched_instr_o <= NOP_INSTR;
                        fetched_valid_o <= 1'b0;
                        state           <= S_MISS;
                    end else begin
                        fetched_instr_o <= icache.iCacheReadData;
                        fetched_pc_o    <= pc_q;
                        fetched_valid_o <= 1'b1;
                        pc_q            <= pc_q + 32'd4;
                        fetch_count_o   <= fetch_count_o + 32'd1;
                        state           <= S_RUN;
                    end
                end
            endcase
        end
    end

endmodule
